// File: rtl/serial_pkg.sv
// Shared definitions for the serial operand transmitter and receiver.
// Bit-order selector, FSM states and counter sizing.
package serial_pkg;

  typedef enum logic {
    SER_LSB_FIRST = 1'b0,
    SER_MSB_FIRST = 1'b1
  } ser_order_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_pair_serializer_if.sv
// Operand-pair handshake in, lock-stepped serial bit pair out.
// The slave side is the serializer itself.
interface serial_pair_serializer_if #(
  parameter int W = 8
);
  logic         up_valid;
  logic         up_ready;
  logic [W-1:0] up_a;
  logic [W-1:0] up_b;
  logic         out_valid;
  logic         a;
  logic         b;
  logic         first;
  logic         last;

  modport master (
    output up_valid, up_a, up_b,
    input  up_ready, out_valid, a, b, first, last
  );

  modport slave (
    input  up_valid, up_a, up_b,
    output up_ready, out_valid, a, b, first, last
  );
endinterface

// File: rtl/serial_shift_lane.sv
// One W-bit parallel-in, serial-out lane with a registered bit output.
// q drops to 0 whenever no word is being shifted.
module serial_shift_lane
  import serial_pkg::*;
#(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         q
);

  localparam ser_order_e ORDER =
    MSB_FIRST ? SER_MSB_FIRST : SER_LSB_FIRST;

  logic [W-1:0] sr;

  // sr holds only the bits still to be sent after q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
      q  <= 1'b0;
    end else if (load) begin
      if (ORDER == SER_MSB_FIRST) begin
        q  <= d[W-1];
        sr <= d << 1;
      end else begin
        q  <= d[0];
        sr <= d >> 1;
      end
    end else if (shift) begin
      if (ORDER == SER_MSB_FIRST) begin
        q  <= sr[W-1];
        sr <= sr << 1;
      end else begin
        q  <= sr[0];
        sr <= sr >> 1;
      end
    end else begin
      q <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_pair_serializer.sv
// Parallel-to-serial transmitter for the a/b comparator streams.
// Word framing via first/last; a handshake on the last bit chains words.
module serial_pair_serializer
  import serial_pkg::*;
#(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  serial_pair_serializer_if.slave bus
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  ser_state_e    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          out_valid;
  logic          first;
  logic          last;
  logic          hs;
  logic          shift;

  assign bus.up_ready  = ~out_valid | last;
  assign hs            = bus.up_valid & bus.up_ready;
  assign shift         = out_valid & ~last;
  assign cnt_nxt       = cnt + CW'(1);
  assign bus.out_valid = out_valid;
  assign bus.first     = first;
  assign bus.last      = last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      first     <= 1'b0;
      last      <= 1'b0;
    end else if (hs) begin
      state     <= ST_SHIFT;
      cnt       <= '0;
      out_valid <= 1'b1;
      first     <= 1'b1;
      last      <= (W == 1);
    end else begin
      unique case (state)
        ST_IDLE: ;
        ST_SHIFT: begin
          if (!last) begin
            cnt   <= cnt_nxt;
            first <= 1'b0;
            last  <= (cnt_nxt == LAST_IDX);
          end else begin
            state     <= ST_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            first     <= 1'b0;
            last      <= 1'b0;
          end
        end
      endcase
    end
  end

  serial_shift_lane #(
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_lane_a (
    .clk   (clk),
    .rst   (rst),
    .load  (hs),
    .shift (shift),
    .d     (bus.up_a),
    .q     (bus.a)
  );

  serial_shift_lane #(
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_lane_b (
    .clk   (clk),
    .rst   (rst),
    .load  (hs),
    .shift (shift),
    .d     (bus.up_b),
    .q     (bus.b)
  );

endmodule

// File: tb/tb_serial_pair_serializer.sv
// Bench for serial_pair_serializer: three instances (W=8 MSB, W=8 LSB,
// W=1) checked cycle by cycle against per-instance queues of expected bits.
module tb_serial_pair_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_pair_serializer_if #(.W(8)) i8m ();
  serial_pair_serializer_if #(.W(8)) i8l ();
  serial_pair_serializer_if #(.W(1)) i1 ();

  serial_pair_serializer #(.W(8), .MSB_FIRST(1'b1)) dut8m (
    .clk (clk), .rst (rst), .bus (i8m)
  );
  serial_pair_serializer #(.W(8), .MSB_FIRST(1'b0)) dut8l (
    .clk (clk), .rst (rst), .bus (i8l)
  );
  serial_pair_serializer #(.W(1), .MSB_FIRST(1'b1)) dut1 (
    .clk (clk), .rst (rst), .bus (i1)
  );

  int tests = 0;
  int fails = 0;

  // entry = {a, b, first, last}; front = bit visible now
  logic [3:0] q8m[$];
  logic [3:0] q8l[$];
  logic [3:0] q1[$];

  function automatic void push(input int id, input int w,
                               input bit msb,
                               input logic [7:0] wa,
                               input logic [7:0] wb);
    for (int k = 0; k < w; k++) begin
      int idx;
      logic [3:0] e;
      idx = msb ? (w - 1 - k) : k;
      e = {wa[idx], wb[idx], k == 0, k == w - 1};
      case (id)
        0: q8m.push_back(e);
        1: q8l.push_back(e);
        default: q1.push_back(e);
      endcase
    end
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("out8m",
        {i8m.out_valid, i8m.a, i8m.b, i8m.first, i8m.last},
        q8m.size() > 0 ? {1'b1, q8m[0]} : 5'b0);
    chk("out8l",
        {i8l.out_valid, i8l.a, i8l.b, i8l.first, i8l.last},
        q8l.size() > 0 ? {1'b1, q8l[0]} : 5'b0);
    chk("out1",
        {i1.out_valid, i1.a, i1.b, i1.first, i1.last},
        q1.size() > 0 ? {1'b1, q1[0]} : 5'b0);
  endtask

  task automatic tick();
    bit h0, h1, h2;
    logic [7:0] a0, b0, a1, b1, a2, b2;
    chk("ready8m", 8'(i8m.up_ready), 8'(q8m.size() <= 1));
    chk("ready8l", 8'(i8l.up_ready), 8'(q8l.size() <= 1));
    chk("ready1", 8'(i1.up_ready), 8'(q1.size() <= 1));
    h0 = i8m.up_valid && (q8m.size() <= 1);
    h1 = i8l.up_valid && (q8l.size() <= 1);
    h2 = i1.up_valid && (q1.size() <= 1);
    a0 = i8m.up_a; b0 = i8m.up_b;
    a1 = i8l.up_a; b1 = i8l.up_b;
    a2 = {7'b0, i1.up_a}; b2 = {7'b0, i1.up_b};
    @(posedge clk);
    if (q8m.size() > 0) void'(q8m.pop_front());
    if (q8l.size() > 0) void'(q8l.pop_front());
    if (q1.size() > 0) void'(q1.pop_front());
    if (h0) push(0, 8, 1'b1, a0, b0);
    if (h1) push(1, 8, 1'b0, a1, b1);
    if (h2) push(2, 1, 1'b1, a2, b2);
    @(negedge clk);
    check_outs();
  endtask

  logic [7:0] abits, bbits;
  int ovcnt, rdycnt;

  initial begin
    rst = 1'b1;
    i8m.up_valid = 0; i8m.up_a = 0; i8m.up_b = 0;
    i8l.up_valid = 0; i8l.up_a = 0; i8l.up_b = 0;
    i1.up_valid = 0; i1.up_a = 0; i1.up_b = 0;
    repeat (2) @(negedge clk);
    check_outs();
    chk("rst_ready8m", 8'(i8m.up_ready), 8'd1);
    chk("rst_ready1", 8'(i1.up_ready), 8'd1);
    rst = 1'b0;
    tick();

    // single word MSB-first
    i8m.up_valid = 1; i8m.up_a = 8'h64; i8m.up_b = 8'h62;
    for (int k = 0; k < 8; k++) begin
      tick();
      i8m.up_valid = 0;
      i8m.up_a = 8'($urandom);
      abits = {abits[6:0], i8m.a};
      bbits = {bbits[6:0], i8m.b};
    end
    chk("msb_a_word", abits, 8'h64);
    chk("msb_b_word", bbits, 8'h62);
    repeat (2) tick();

    // back-to-back with up_valid held
    ovcnt = 0; rdycnt = 0;
    i8m.up_valid = 1; i8m.up_a = 8'h80; i8m.up_b = 8'h01;
    tick();
    ovcnt += int'(i8m.out_valid);
    i8m.up_a = 8'h01; i8m.up_b = 8'h80;
    repeat (8) begin
      rdycnt += int'(i8m.up_ready);
      tick();
      ovcnt += int'(i8m.out_valid);
    end
    i8m.up_valid = 0;
    repeat (9) begin
      rdycnt += int'(i8m.up_ready);
      tick();
      ovcnt += int'(i8m.out_valid);
    end
    chk("b2b_len", 8'(ovcnt), 8'd16);
    chk("b2b_ready", 8'(rdycnt), 8'd3);

    // LSB-first
    i8l.up_valid = 1; i8l.up_a = 8'h01; i8l.up_b = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      tick();
      i8l.up_valid = 0;
      abits = {abits[6:0], i8l.a};
    end
    chk("lsb_a_seq", abits, 8'h80);
    tick();

    // W=1 pairs
    i1.up_valid = 1; i1.up_a = 1'b1; i1.up_b = 1'b0;
    tick();
    i1.up_a = 1'b0; i1.up_b = 1'b1;
    tick();
    i1.up_valid = 0;
    repeat (2) tick();

    // reset in the middle of a word
    i8m.up_valid = 1; i8m.up_a = 8'hFF; i8m.up_b = 8'($urandom);
    tick();
    i8m.up_valid = 0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("rst_mid",
        {i8m.out_valid, i8m.a, i8m.first, i8m.last}, 8'd0);
    q8m.delete(); q8l.delete(); q1.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    i8m.up_valid = 1; i8m.up_a = 8'($urandom);
    tick();
    chk("post_rst_first", 8'(i8m.first), 8'd1);
    i8m.up_valid = 0;
    repeat (8) tick();

    // data wiggle without valid
    repeat (5) begin
      i8m.up_a = 8'($urandom);
      i8l.up_a = 8'($urandom);
      i1.up_a = 1'($urandom);
      tick();
    end

    // random traffic on all three
    repeat (300) begin
      i8m.up_valid = ($urandom_range(0, 3) != 0);
      i8m.up_a = 8'($urandom); i8m.up_b = 8'($urandom);
      i8l.up_valid = ($urandom_range(0, 1) != 0);
      i8l.up_a = 8'($urandom); i8l.up_b = 8'($urandom);
      i1.up_valid = ($urandom_range(0, 2) != 0);
      i1.up_a = 1'($urandom); i1.up_b = 1'($urandom);
      tick();
    end
    i8m.up_valid = 0; i8l.up_valid = 0; i1.up_valid = 0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
